// File: rtl/ann_pkg.sv
// Shared state encoding and default layer table for the layer sequencer.
// Slice k of the table (bits k*7 +: 7) is the input count of layer k.
package ann_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_COEF,
    WAIT_COEF,
    START_LAYER,
    RUN_LAYER,
    ADVANCE,
    DONE,
    ERROR
  } seq_state_t;

  localparam logic [20:0] DEF_LAYER_INPUTS = {7'd10, 7'd4, 7'd16};

endpackage

// File: rtl/ann_layer_sequencer_if.sv
// Control bundle between the sequencer (master) and loader/SRAM/node array (slave).
// Inputs are levels sampled on clk; no backpressure beyond the coef_req/coef_ack handshake.
interface ann_layer_sequencer_if #(
  parameter int NUM_LAYERS = 3,
  parameter int IN_W       = 7
);
  localparam int LIDX_W = $clog2(NUM_LAYERS + 1);

  logic                  start;
  logic                  abort;
  logic                  coef_ack;
  logic                  layer_done;
  logic [LIDX_W-1:0]     layer_idx;
  logic [IN_W-1:0]       max_input;
  logic                  coef_req;
  logic                  reset_accum;
  logic                  coeff_ready;
  logic [NUM_LAYERS:0]   load_en;
  logic                  busy;
  logic                  done_processing;
  logic                  timeout_err;

  modport master (
    input  start, abort, coef_ack, layer_done,
    output layer_idx, max_input, coef_req, reset_accum, coeff_ready,
           load_en, busy, done_processing, timeout_err
  );

  modport slave (
    output start, abort, coef_ack, layer_done,
    input  layer_idx, max_input, coef_req, reset_accum, coeff_ready,
           load_en, busy, done_processing, timeout_err
  );

endinterface

// File: rtl/ann_watchdog.sv
// Cycle counter for wait states; o_expire is combinational, high on the TIMEOUT-th enabled cycle.
// i_clear overrides i_enable; TIMEOUT=0 freezes the counter and never expires.
module ann_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned    LIM   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TO_W-1:0] LIM_V = TO_W'(LIM);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (TIMEOUT != 0)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (TIMEOUT != 0) && i_enable && (r_cnt == LIM_V);

endmodule

// File: rtl/ann_layer_sequencer.sv
// Sequences coefficient fetch, accumulator clear, run and result load per layer; min 4 cycles/layer.
// Stalls on coef_ack and layer_done with a watchdog; abort cancels any non-IDLE state.
import ann_pkg::*;

module ann_layer_sequencer #(
  parameter int                         NUM_LAYERS   = 3,
  parameter int                         IN_W         = 7,
  parameter logic [NUM_LAYERS*IN_W-1:0] LAYER_INPUTS = DEF_LAYER_INPUTS,
  parameter int                         TIMEOUT      = 1024,
  parameter int                         TO_W         = 11
) (
  input logic                 clk,
  input logic                 n_rst,
  ann_layer_sequencer_if.master bus
);

  localparam int                  LIDX_W  = $clog2(NUM_LAYERS + 1);
  localparam logic [NUM_LAYERS:0] LD_ONE  = 1;
  localparam logic [LIDX_W-1:0]   LAST_IX = LIDX_W'(NUM_LAYERS - 1);

  seq_state_t          r_state, w_next;
  logic [LIDX_W-1:0]   r_layer_idx;
  logic                r_timeout_err;
  logic                w_expire;
  logic                w_wd_en;
  logic                w_wd_clr;
  logic [IN_W-1:0]     w_max_input;
  logic [NUM_LAYERS:0] w_load_en;

  assign w_wd_en  = (r_state == WAIT_COEF) || (r_state == RUN_LAYER);
  assign w_wd_clr = (w_next != r_state);

  ann_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_clear  (w_wd_clr),
    .i_enable (w_wd_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // abort outranks everything outside IDLE; layer_done/coef_ack outrank expiry
  always_comb begin
    w_next = r_state;
    if (r_state != IDLE && bus.abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:        if (bus.start) w_next = REQ_COEF;
        REQ_COEF:    w_next = bus.coef_ack ? START_LAYER : WAIT_COEF;
        WAIT_COEF:   if (bus.coef_ack) w_next = START_LAYER;
                     else if (w_expire) w_next = ERROR;
        START_LAYER: w_next = RUN_LAYER;
        RUN_LAYER:   if (bus.layer_done) w_next = ADVANCE;
                     else if (w_expire) w_next = ERROR;
        ADVANCE:     w_next = (r_layer_idx == LAST_IX) ? DONE : REQ_COEF;
        DONE:        w_next = IDLE;
        ERROR:       w_next = ERROR;
        default:     w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_layer_idx   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_next == IDLE) begin
        r_layer_idx <= '0;
      end else if (r_state == ADVANCE) begin
        r_layer_idx <= r_layer_idx + 1'b1;
      end
      if (r_state == IDLE && bus.start) begin
        r_timeout_err <= 1'b0;
      end else if (w_next == ERROR && r_state != ERROR) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_max_input = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (r_layer_idx == LIDX_W'(k)) begin
        w_max_input = LAYER_INPUTS[k*IN_W +: IN_W];
      end
    end
  end

  always_comb begin
    w_load_en = '0;
    if (r_state == IDLE) begin
      w_load_en = LD_ONE;
    end else if (r_state == ADVANCE) begin
      w_load_en = LD_ONE << (r_layer_idx + 1'b1);
    end
  end

  assign bus.layer_idx       = r_layer_idx;
  assign bus.max_input       = w_max_input;
  assign bus.coef_req        = (r_state == REQ_COEF) || (r_state == WAIT_COEF);
  assign bus.reset_accum     = (r_state == START_LAYER);
  assign bus.coeff_ready     = (r_state == RUN_LAYER);
  assign bus.load_en         = w_load_en;
  assign bus.busy            = (r_state != IDLE);
  assign bus.done_processing = (r_state == DONE);
  assign bus.timeout_err     = r_timeout_err;

endmodule
